hv_chunk_feeder: RTL and testbench
==================================

Name: hv_chunk_feeder

Overview:
- Upstream driver for the pipelined adder tree. It feeds one encoding dimension at a time.
- Accepts one signed feature-product element per beat over a valid/ready stream and packs FTSIZE elements into a chunk.
- Issues each chunk to the tree and closes the accumulation loop by driving tree_last_in with the running sum.
- After NUM_CHUNKS chunks, presents the final dimension sum on a valid/ready result port.

Parameters:
INPUT_WIDTH, 8, width of one signed feature-product element
DIM_WIDTH, 16, width of accumulated dimension sum (two's complement)
FTSIZE, 16, elements per chunk (tree fan-in)
NUM_CHUNKS, 4, chunks per dimension sum (features per sum = FTSIZE*NUM_CHUNKS)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  element stream valid
in_ready  output  1  element stream ready
in_data  input  INPUT_WIDTH  signed element
tree_inputs  output  FTSIZE*INPUT_WIDTH  packed chunk to tree; element k in bits [k*INPUT_WIDTH +: INPUT_WIDTH]
tree_last_in  output  DIM_WIDTH  running sum to tree
tree_out  input  DIM_WIDTH  tree result, registered, 1-cycle latency
sum_valid  output  1  result valid
sum_ready  input  1  result accepted
sum_data  output  DIM_WIDTH  final dimension sum
busy  output  1  high in every state except FILL with elem_cnt=0 and chunk_cnt=0

Behaviour:
- Reset (reset=0, async): state=FILL, elem_cnt=0, chunk_cnt=0, acc=0, chunk register=0.
  - Outputs during/after reset: in_ready=1, sum_valid=0, sum_data=0, tree_inputs=0, tree_last_in=0, busy=0.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: chunk[elem_cnt] <= in_data; elem_cnt++.
  - When element FTSIZE-1 is accepted: elem_cnt <= 0 and go to ISSUE.
  - No accept in any other state (in_ready=0).
- ISSUE, exactly 1 cycle:
  - tree_inputs = chunk register.
  - tree_last_in = 0 if chunk_cnt==0, else acc.
  - Next state CAPTURE.
- CAPTURE, 1 cycle:
  - acc <= tree_out (the tree's registered result of ISSUE).
  - If chunk_cnt==NUM_CHUNKS-1: go to OUT.
  - Else: chunk_cnt++ and go to FILL.
- OUT:
  - sum_valid=1 and sum_data=acc.
  - sum_data is held stable until sum_valid&&sum_ready.
  - On handshake: chunk_cnt <= 0 and go to FILL; sum_valid drops the next cycle.
- Outside ISSUE: tree_inputs=0 and tree_last_in=0, so the tree idles at 0.
- sum_data=0 whenever sum_valid=0.
- Arithmetic:
  - The tree sign-extends elements.
  - All sums wrap modulo 2^DIM_WIDTH; no saturation and no overflow flag.
- Latency:
  - Final element accepted in cycle t: ISSUE at t+1, CAPTURE at t+2, sum_valid=1 at t+3.
  - Per chunk: FTSIZE accept cycles + 2.
- Throughput: in_ready=0 during ISSUE, CAPTURE and OUT; upstream must tolerate these stalls.
- in_valid=0 mid-chunk: the partial chunk is held indefinitely; counters are unchanged.
- sum_ready held low: stay in OUT; in_ready stays 0 and no new elements are accepted.
- sum_ready already high on entry to OUT: handshake in the first OUT cycle; FILL resumes the next cycle.
- Reset asserted mid-operation: partial chunk and acc are discarded; no result is emitted for the aborted sum.

Test Plan:
- 64 elements of value 1, sum_ready=1 -> one sum_valid pulse with sum_data=0x0040, asserted exactly 3 cycles after the 64th accept.
- Each chunk = {-1 x4, 11 x4, -1 x4, 11 x4}, 4 chunks -> sum_data=0x0140 (80 per chunk, 320 total).
- 64 elements of value -1 -> sum_data=0xFFC0.
- Back-to-back sums: first all 2 (=128), then all 127 (=8128):
  - expect 0x0080, then 0x1FC0.
  - Second sum's first chunk must use tree_last_in=0 (no carry-over from the first sum).
- Backpressure:
  - Toggle in_valid randomly and hold sum_ready=0 for 10 cycles in OUT -> sum_data stable, in_ready=0 throughout, correct sum after release.
  - Check in_ready=0 during every ISSUE and CAPTURE cycle.
- Assert reset=0 after 37 accepted elements, release, then send 64 elements of value 3 -> sum_data=0x00C0; all outputs at reset values during reset.

Source files
------------

// File: rtl/hv_chunk_feeder.sv
// hv_chunk_feeder: packs a signed element stream into FTSIZE-wide chunks,
// feeds them to an external registered adder tree, and closes the
// accumulation loop through tree_last_in. After NUM_CHUNKS chunks it presents
// the dimension sum on a valid/ready result port.

// One chunk lane: holds a single element and shows it to the tree only while issuing.
module hv_chunk_feeder_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic         issue,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r;

  // Element storage, written when this lane is the current fill slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r <= '0;
    else if (we) r <= d;
  end

  assign q = issue ? r : '0;
endmodule

module hv_chunk_feeder #(
  parameter int INPUT_WIDTH = 8,
  parameter int DIM_WIDTH   = 16,
  parameter int FTSIZE      = 16,
  parameter int NUM_CHUNKS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_WIDTH-1:0]        in_data,
  output logic [FTSIZE*INPUT_WIDTH-1:0] tree_inputs,
  output logic [DIM_WIDTH-1:0]          tree_last_in,
  input  logic [DIM_WIDTH-1:0]          tree_out,
  output logic                          sum_valid,
  input  logic                          sum_ready,
  output logic [DIM_WIDTH-1:0]          sum_data,
  output logic                          busy
);
  localparam int EW = (FTSIZE > 1) ? $clog2(FTSIZE) : 1;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {FILL, ISSUE, CAPTURE, OUT} state_t;

  state_t                                  state, state_n;
  logic [EW-1:0]                           elem_cnt;
  logic [CW-1:0]                           chunk_cnt;
  logic [DIM_WIDTH-1:0]                    acc;
  logic [FTSIZE-1:0][INPUT_WIDTH-1:0]      lane_q;
  logic                                    accept, last_elem, last_chunk, issue;

  assign accept     = in_valid && in_ready;
  assign last_elem  = (elem_cnt == EW'(FTSIZE - 1));
  assign last_chunk = (chunk_cnt == CW'(NUM_CHUNKS - 1));
  assign issue      = (state == ISSUE);

  // Chunk register, one lane per tree input; lanes read as zero outside ISSUE.
  for (genvar k = 0; k < FTSIZE; k++) begin : g_lane
    hv_chunk_feeder_lane #(.W(INPUT_WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (accept && (elem_cnt == EW'(k))),
      .issue (issue),
      .d     (in_data),
      .q     (lane_q[k])
    );
  end

  assign tree_inputs = lane_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_n;
  end

  // Next state and handshake/result outputs.
  always_comb begin
    state_n      = state;
    in_ready     = 1'b0;
    sum_valid    = 1'b0;
    sum_data     = '0;
    tree_last_in = '0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && last_elem) state_n = ISSUE;
      end
      ISSUE: begin
        // First chunk of a sum starts from zero so nothing carries across sums.
        tree_last_in = (chunk_cnt == '0) ? '0 : acc;
        state_n      = CAPTURE;
      end
      CAPTURE: state_n = last_chunk ? OUT : FILL;
      OUT: begin
        sum_valid = 1'b1;
        sum_data  = acc;
        if (sum_ready) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  // Element/chunk counters and the running sum taken from the tree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt  <= '0;
      chunk_cnt <= '0;
      acc       <= '0;
    end else begin
      case (state)
        FILL:    if (accept) elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
        CAPTURE: begin
          acc <= tree_out;
          if (!last_chunk) chunk_cnt <= chunk_cnt + 1'b1;
        end
        OUT:     if (sum_ready) chunk_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign busy = !((state == FILL) && (elem_cnt == '0) && (chunk_cnt == '0));
endmodule

// File: tb/tb_hv_chunk_feeder.sv
// Bench for hv_chunk_feeder: registered adder-tree model, directed element
// streams, expected sums queued by the driver and checked by a monitor.
module tb_hv_chunk_feeder;
  localparam int IW = 8, DW = 16, FT = 16, NC = 4, NE = FT * NC;

  logic              clk = 0, reset = 0;
  logic              in_valid = 0, in_ready;
  logic [IW-1:0]     in_data = '0;
  logic [FT*IW-1:0]  tree_inputs;
  logic [DW-1:0]     tree_last_in, tree_out = '0, sum_data, tree_comb;
  logic              sum_valid, sum_ready = 1, busy;

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int el[NE];
  bit held = 0;
  logic [DW-1:0] held_val;

  hv_chunk_feeder #(.INPUT_WIDTH(IW), .DIM_WIDTH(DW), .FTSIZE(FT), .NUM_CHUNKS(NC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_inputs(tree_inputs), .tree_last_in(tree_last_in), .tree_out(tree_out),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data), .busy(busy));

  always #5 clk = ~clk;

  // Adder tree model: sign-extended lanes plus last_in, one register stage.
  always_comb begin
    tree_comb = tree_last_in;
    for (int k = 0; k < FT; k++) tree_comb = tree_comb + DW'($signed(tree_inputs[k*IW +: IW]));
  end
  always @(posedge clk) tree_out <= tree_comb;

  task automatic chk(input string nm, input logic [FT*IW-1:0] act, input logic [FT*IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result monitor: pops the scoreboard on each handshake, checks holding rules.
  always @(negedge clk) begin
    if (sum_valid) begin
      chk("out_busy", busy, 1);
      chk("out_in_ready", in_ready, 0);
      if (held) chk("out_stable", sum_data, held_val);
      if (sum_ready) begin
        held = 0;
        if (exp_q.size() == 0) chk("unexpected_sum", sum_data, 'x);
        else chk("sum_data", sum_data, exp_q.pop_front());
      end else begin
        held = 1;
        held_val = sum_data;
      end
    end else begin
      held = 0;
      if (sum_data !== '0) chk("sum_data_idle", sum_data, 0);
    end
  end

  task automatic fill_const(input int v);
    for (int i = 0; i < NE; i++) el[i] = v;
  endtask

  task automatic send_elem(input int v, input bit gap);
    bit done = 0;
    int tries = 0;
    while (!done) begin
      @(negedge clk);
      in_data  = v[IW-1:0];
      in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) done = 1;
      tries++;
      if (!done && tries > 200) begin
        chk("accept_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk);
    end
  endtask

  // Stream n elements of el[]; checks ISSUE/CAPTURE timing per chunk and the
  // 3-cycle result latency; optional backpressure hold of `hold` cycles.
  task automatic send_run(input int n, input bit push, input logic [DW-1:0] expv,
                          input bit gap, input int hold);
    logic [DW-1:0]    run = '0;
    logic [FT*IW-1:0] exp_ti;
    int c;
    if (push) exp_q.push_back(expv);
    for (int i = 0; i < n; i++) begin
      send_elem(el[i], gap);
      if (i % FT == FT - 1) begin
        c = i / FT;
        for (int k = 0; k < FT; k++) exp_ti[k*IW +: IW] = el[c*FT + k][IW-1:0];
        @(negedge clk);
        in_valid = 0;
        chk("issue_in_ready", in_ready, 0);
        chk("issue_last_in", tree_last_in, run);
        chk("issue_tree_inputs", tree_inputs, exp_ti);
        for (int k = 0; k < FT; k++) run = run + DW'(el[c*FT + k]);
        @(negedge clk);
        chk("capture_in_ready", in_ready, 0);
        chk("capture_tree_idle", tree_inputs, 0);
        if (c == NC - 1) begin
          @(negedge clk);
          chk("latency_sum_valid", sum_valid, 1);
          if (hold > 0) begin
            repeat (hold) begin
              @(negedge clk);
              chk("hold_sum_valid", sum_valid, 1);
            end
            @(posedge clk);
            #1 sum_ready = 1;
            @(posedge clk);
            #1;
          end
        end
      end
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_tree_inputs", tree_inputs, 0);
    chk("rst_tree_last_in", tree_last_in, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outs();
    reset = 1;

    fill_const(1);
    send_run(NE, 1, 16'h0040, 0, 0);

    for (int i = 0; i < NE; i++) el[i] = (((i % FT) / 4) % 2 == 0) ? -1 : 11;
    send_run(NE, 1, 16'h0140, 0, 0);

    fill_const(-1);
    send_run(NE, 1, 16'hFFC0, 0, 0);

    fill_const(2);
    send_run(NE, 1, 16'h0080, 0, 0);
    fill_const(127);
    send_run(NE, 1, 16'h1FC0, 0, 0);

    // Random valid gaps plus a 10-cycle result stall.
    fill_const(5);
    @(negedge clk);
    sum_ready = 0;
    send_run(NE, 1, 16'h0140, 1, 10);

    // Abort a sum mid-chunk, then a clean sum of 3s.
    fill_const(7);
    send_run(37, 0, '0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    reset = 0;
    #1 chk_reset_outs();
    @(negedge clk);
    chk_reset_outs();
    reset = 1;
    fill_const(3);
    send_run(NE, 1, 16'h00C0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end
endmodule
